// File: rtl/mux_arb_pipe.sv
// NUM_IN-way valid/ready mux with explicit-select and round-robin modes,
// forwarding the granted beat through a single registered output stage.
module mux_arb_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [NUM_IN*WIDTH-1:0] In_data,
  input  logic [NUM_IN-1:0]       In_valid,
  output logic [NUM_IN-1:0]       In_ready,
  input  logic                    Mode,
  input  logic [SEL_W-1:0]        Sel,
  output logic [WIDTH-1:0]        Out_data,
  output logic                    Out_valid,
  output logic [SEL_W-1:0]        Out_src,
  input  logic                    Out_ready
);

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_out_src;
  logic [SEL_W-1:0] r_rr_ptr;

  logic             w_load;
  logic             w_grant_valid;
  logic [SEL_W-1:0] w_grant_idx;
  logic [WIDTH-1:0] w_grant_data;

  // Channel k steps after base, wrapping past NUM_IN-1 back to 0.
  function automatic logic [SEL_W-1:0] rr_idx(input logic [SEL_W-1:0] base, input int k);
    int t;
    t = int'(base) + k;
    if (t >= NUM_IN) t = t - NUM_IN;
    return t[SEL_W-1:0];
  endfunction

  assign w_load = !r_out_valid || Out_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    if (!Mode) begin
      // Sel values outside 0..NUM_IN-1 never match, so they yield no grant.
      for (int i = 0; i < NUM_IN; i++) begin
        if (Sel == SEL_W'(i) && In_valid[i]) begin
          w_grant_valid = 1'b1;
          w_grant_idx   = SEL_W'(i);
        end
      end
    end else begin
      // Walk from farthest to nearest so the first valid after rr_ptr wins.
      for (int k = NUM_IN; k >= 1; k--) begin
        if (In_valid[rr_idx(r_rr_ptr, k)]) begin
          w_grant_valid = 1'b1;
          w_grant_idx   = rr_idx(r_rr_ptr, k);
        end
      end
    end
  end

  assign w_grant_data = In_data[w_grant_idx*WIDTH +: WIDTH];

  always_comb begin
    In_ready = '0;
    if (!Reset && w_load && w_grant_valid) In_ready[w_grant_idx] = 1'b1;
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (Reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_rr_ptr    <= SEL_W'(NUM_IN - 1);
    end else if (w_load) begin
      r_out_valid <= w_grant_valid;
      if (w_grant_valid) begin
        r_out_data <= w_grant_data;
        r_out_src  <= w_grant_idx;
        if (Mode) r_rr_ptr <= w_grant_idx;
      end
    end
  end

  assign Out_data  = r_out_data;
  assign Out_valid = r_out_valid;
  assign Out_src   = r_out_src;

endmodule

// File: tb/tb_mux_arb_pipe.sv
// Table-driven bench for mux_arb_pipe: per-cycle vectors with hand-derived
// expectations plus a scoreboard of accepted beats checked as they drain.
module tb_mux_arb_pipe;

  localparam int WIDTH  = 32;
  localparam int NUM_IN = 4;
  localparam int SEL_W  = 2;

  logic                    Clk;
  logic                    Reset;
  logic [NUM_IN*WIDTH-1:0] In_data;
  logic [NUM_IN-1:0]       In_valid;
  logic [NUM_IN-1:0]       In_ready;
  logic                    Mode;
  logic [SEL_W-1:0]        Sel;
  logic [WIDTH-1:0]        Out_data;
  logic                    Out_valid;
  logic [SEL_W-1:0]        Out_src;
  logic                    Out_ready;

  mux_arb_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .In_data  (In_data),
    .In_valid (In_valid),
    .In_ready (In_ready),
    .Mode     (Mode),
    .Sel      (Sel),
    .Out_data (Out_data),
    .Out_valid(Out_valid),
    .Out_src  (Out_src),
    .Out_ready(Out_ready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic                    rst;
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [NUM_IN-1:0]       valid;
    logic                    ready;
    logic [NUM_IN*WIDTH-1:0] data;
    logic [NUM_IN-1:0]       exp_ir;
    logic                    exp_ov;
    logic [SEL_W-1:0]        exp_src;
    logic [WIDTH-1:0]        exp_data;
  } vec_t;

  typedef struct {
    logic [SEL_W-1:0] src;
    logic [WIDTH-1:0] data;
  } beat_t;

  vec_t  vecs[$];
  beat_t sb[$];
  int    n_pass = 0;
  int    n_total = 0;

  localparam logic [NUM_IN*WIDTH-1:0] DA = {32'h13, 32'hDEADBEEF, 32'h11, 32'h10};
  localparam logic [NUM_IN*WIDTH-1:0] DB = {32'h13, 32'h12, 32'h11, 32'h10};

  function automatic vec_t mk(logic rst, logic mode, logic [SEL_W-1:0] sel,
                              logic [NUM_IN-1:0] valid, logic ready,
                              logic [NUM_IN*WIDTH-1:0] data, logic [NUM_IN-1:0] exp_ir,
                              logic exp_ov, logic [SEL_W-1:0] exp_src, logic [WIDTH-1:0] exp_data);
    vec_t v;
    v.rst = rst; v.mode = mode; v.sel = sel; v.valid = valid; v.ready = ready;
    v.data = data; v.exp_ir = exp_ir; v.exp_ov = exp_ov; v.exp_src = exp_src;
    v.exp_data = exp_data;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // One clock cycle: drive at negedge, check ready and drain before the edge,
  // check the registered outputs just after it.
  task automatic apply(input vec_t v);
    beat_t b;
    @(negedge Clk);
    Reset     = v.rst;
    Mode      = v.mode;
    Sel       = v.sel;
    In_valid  = v.valid;
    Out_ready = v.ready;
    In_data   = v.data;
    #1;
    check("in_ready", 32'(In_ready), 32'(v.exp_ir));
    if (!v.rst && Out_valid && Out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_beat", 32'(Out_src), 32'hFFFF_FFFF);
      end else begin
        b = sb.pop_front();
        check("sb_src", 32'(Out_src), 32'(b.src));
        check("sb_data", Out_data, b.data);
      end
    end
    if (v.exp_ir != '0) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (v.exp_ir[i]) begin
          b.src  = SEL_W'(i);
          b.data = v.data[i*WIDTH +: WIDTH];
          sb.push_back(b);
        end
      end
    end
    @(posedge Clk);
    #1;
    if (v.rst) sb.delete();
    check("out_valid", 32'(Out_valid), 32'(v.exp_ov));
    check("out_src", 32'(Out_src), 32'(v.exp_src));
    check("out_data", Out_data, v.exp_data);
  endtask

  initial begin
    Reset = 1'b1; Mode = 1'b0; Sel = '0; In_valid = '0; Out_ready = 1'b0; In_data = '0;

    // reset: outputs cleared, In_ready forced low even with every channel valid
    vecs.push_back(mk(1, 1, 0, 4'b1111, 1, DB, 4'b0000, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 0, 4'b1111, 1, DB, 4'b0000, 0, 0, 32'h0));
    // explicit select
    vecs.push_back(mk(0, 0, 2, 4'b0100, 1, DA, 4'b0100, 1, 2, 32'hDEADBEEF));
    vecs.push_back(mk(0, 0, 1, 4'b0001, 1, DA, 4'b0000, 0, 2, 32'hDEADBEEF));
    vecs.push_back(mk(0, 0, 3, 4'b1000, 0, DA, 4'b1000, 1, 3, 32'h13));
    vecs.push_back(mk(0, 0, 0, 4'b0001, 0, DA, 4'b0000, 1, 3, 32'h13));
    // round-robin, all valid, full throughput: 0,1,2,3,0,1,2,3
    vecs.push_back(mk(0, 1, 0, 4'b1111, 1, DB, 4'b0001, 1, 0, 32'h10));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 1, DB, 4'b0010, 1, 1, 32'h11));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 1, DB, 4'b0100, 1, 2, 32'h12));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 1, DB, 4'b1000, 1, 3, 32'h13));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 1, DB, 4'b0001, 1, 0, 32'h10));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 1, DB, 4'b0010, 1, 1, 32'h11));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 1, DB, 4'b0100, 1, 2, 32'h12));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 1, DB, 4'b1000, 1, 3, 32'h13));
    // stall for 3 cycles after beat src0; Mode/Sel wiggle must not disturb it
    vecs.push_back(mk(0, 1, 0, 4'b1111, 1, DB, 4'b0001, 1, 0, 32'h10));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 0, DB, 4'b0000, 1, 0, 32'h10));
    vecs.push_back(mk(0, 0, 3, 4'b1111, 0, DB, 4'b0000, 1, 0, 32'h10));
    vecs.push_back(mk(0, 1, 2, 4'b1111, 0, DB, 4'b0000, 1, 0, 32'h10));
    vecs.push_back(mk(0, 1, 0, 4'b1111, 1, DB, 4'b0010, 1, 1, 32'h11));
    // wrap-around: move pointer to 3, then 1001 grants 0 then 3
    vecs.push_back(mk(0, 1, 0, 4'b1000, 1, DB, 4'b1000, 1, 3, 32'h13));
    vecs.push_back(mk(0, 1, 0, 4'b1001, 1, DB, 4'b0001, 1, 0, 32'h10));
    vecs.push_back(mk(0, 1, 0, 4'b1001, 1, DB, 4'b1000, 1, 3, 32'h13));
    vecs.push_back(mk(0, 1, 0, 4'b0000, 1, DB, 4'b0000, 0, 3, 32'h13));

    foreach (vecs[i]) apply(vecs[i]);

    // reset while a beat is held under backpressure; beat is dropped, then ch0 first
    apply(mk(0, 1, 0, 4'b0010, 0, DB, 4'b0010, 1, 1, 32'h11));
    apply(mk(0, 1, 0, 4'b1111, 0, DB, 4'b0000, 1, 1, 32'h11));
    apply(mk(1, 1, 0, 4'b1111, 0, DB, 4'b0000, 0, 0, 32'h0));
    apply(mk(0, 1, 0, 4'b1111, 1, DB, 4'b0001, 1, 0, 32'h10));
    apply(mk(0, 1, 0, 4'b0000, 1, DB, 4'b0000, 0, 0, 32'h10));

    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mux_arb_pipe.md
Name: mux_arb_pipe

Overview:
- Parametrised successor to the team's registered 2:1 data mux.
- Selects one of NUM_IN valid/ready input channels of WIDTH bits and forwards it through a registered output stage with full backpressure.
- Two selection modes: explicit select (Sel-driven) and round-robin arbitration.
- Sits between multiple producers and a single consumer in the datapath; the output register gives one cycle of latency and full throughput.

Parameters:
- WIDTH, 32, data width per channel (>=1).
- NUM_IN, 4, number of input channels (>=2).
- SEL_W, $clog2(NUM_IN), width of select/source fields (derived; do not override).

Ports:
- Clk  input  1  clock; all logic on posedge.
- Reset  input  1  synchronous, active-high reset.
- In_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- In_valid  input  NUM_IN  per-channel valid.
- In_ready  output  NUM_IN  per-channel ready; one-hot or zero.
- Mode  input  1  0 = explicit select, 1 = round-robin.
- Sel  input  SEL_W  channel index used in Mode 0.
- Out_data  output  WIDTH  registered selected data.
- Out_valid  output  1  registered valid.
- Out_src  output  SEL_W  index of the channel that produced Out_data.
- Out_ready  input  1  consumer ready.

Behaviour:
- Reset is synchronous and active-high on Clk. While Reset is high at a posedge:
  - Out_valid=0, Out_data=0, Out_src=0.
  - rr_ptr=NUM_IN-1, so channel 0 has first priority.
  - In_ready is held all-zero combinationally during Reset.
- Reset mid-transfer drops any held beat; no transfer completes on a reset cycle.
- Load enable: load = !Out_valid || Out_ready (combinational).
- Grant, Mode 0:
  - Granted channel = Sel, if Sel < NUM_IN and In_valid[Sel].
  - Otherwise there is no grant. Sel >= NUM_IN is always no-grant.
- Grant, Mode 1:
  - Search channels rr_ptr+1, rr_ptr+2, … modulo NUM_IN, wrapping past NUM_IN-1 to 0.
  - The first channel with In_valid set is granted.
- In_ready[g] = load && grant_valid, only for the granted channel g; all other bits are 0.
- Input transfer on channel i happens when In_valid[i] && In_ready[i].
- On a posedge with load=1:
  - Out_valid <= grant_valid.
  - If grant_valid: Out_data <= channel g data, Out_src <= g.
  - If no grant: Out_data and Out_src hold their previous values.
- On a posedge with load=0 (Out_valid && !Out_ready): Out_data, Out_src and Out_valid hold. No input is accepted.
- Output transfer happens when Out_valid && Out_ready.
- Latency: input handshake at cycle N gives Out_valid at cycle N+1.
- Throughput: one beat per cycle while Out_ready stays high. A simultaneous output drain and input load in the same cycle is allowed.
- rr_ptr <= g only on an input transfer in Mode 1. Mode 0 transfers and idle cycles leave rr_ptr unchanged.
- Mode and Sel are sampled every cycle. Changing them while stalled does not alter the held output beat.
- A producer may drop In_valid while not granted; no data is lost because nothing is accepted without In_ready.
- Full = Out_valid && !Out_ready. Empty = !Out_valid. No internal buffering beyond the single output register.

Test Plan:
- Reset released, Mode 0, Sel=2, In_valid=4'b0100, channel 2 data=32'hDEADBEEF, Out_ready=1 -> In_ready=4'b0100; next cycle Out_valid=1, Out_data=32'hDEADBEEF, Out_src=2.
- Mode 0, Sel=1, In_valid=4'b0001 -> In_ready=0; Out_valid=0 next cycle; Out_data holds its previous value.
- Mode 1, all four valid with data 0x10,0x11,0x12,0x13, Out_ready=1 for 8 cycles -> Out_src sequence 0,1,2,3,0,1,2,3 and data in the matching order at one beat per cycle.
- Mode 1, Out_ready=0 for 3 cycles after the first beat (0x10, src 0) -> Out_data stays 0x10 and In_ready=0 for those cycles; with Out_ready=1 the next beat is src 1 (0x11) with no skipped or duplicated beat.
- Mode 1, In_valid=4'b1001, rr_ptr=3 -> grant 0 (wrap-around); next cycle, with the same valids, grant 3.
- Reset asserted while Out_valid=1 and Out_ready=0 -> next cycle Out_valid=0, Out_data=0, Out_src=0; after release, Mode 1 grants channel 0 first.
